// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 256x8 data memory that is filled from a byte loader, then serves CPU reads/writes.
// Optional feature: define DMEM_WPROT_EN to write-protect addresses 0..PROT_TOP during RUN.
module dmem_responder #(
    parameter logic [7:0] IO_ADDR   = 8'hFF,
    parameter logic [7:0] STAT_ADDR = 8'hFE,
    parameter logic [7:0] PROT_TOP  = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] mem_in,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       cpu_rst,
    output logic [7:0] io_out,
    output logic       io_stb,
    output logic       bus_err
);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t      r_state;
    logic [7:0]  r_ld_ptr;
    logic [7:0]  r_io_out;
    logic        r_io_stb;
    logic        r_bus_err;
    logic        r_cpu_rst;
    logic [7:0]  r_mem [256];

    logic        w_run;
    logic        w_load_acc;
    logic        w_prot_hit;
    logic        w_cpu_wr;
    logic        w_io_wr;
    logic        w_mem_cpu_wr;
    logic        w_conflict;
    logic        w_prot_err;
    logic [7:0]  w_rd_data;

`ifdef DMEM_WPROT_EN
    assign w_prot_hit = (addr <= PROT_TOP);
`else
    assign w_prot_hit = 1'b0 && (addr <= PROT_TOP);
`endif

    assign w_run        = rst && (r_state == RUN);
    assign w_load_acc   = rst && (r_state == LOAD) && ld_valid;
    assign w_cpu_wr     = w_run && !W && R && !w_prot_hit;
    assign w_io_wr      = w_cpu_wr && (addr == IO_ADDR);
    assign w_mem_cpu_wr = w_cpu_wr && (addr != IO_ADDR) && (addr != STAT_ADDR);
    // A simultaneous read+write is a CPU protocol violation: the read wins.
    assign w_conflict   = w_run && !R && !W;
    assign w_prot_err   = w_run && !W && R && w_prot_hit;

    always_comb begin
        w_rd_data = 8'h00;
        if (w_run && !R) begin
            if (addr == IO_ADDR)
                w_rd_data = r_io_out;
            else if (addr == STAT_ADDR)
                w_rd_data = {7'b0, r_bus_err};
            else
                w_rd_data = r_mem[addr];
        end
    end

    // Storage is deliberately not reset so a reload keeps earlier contents.
    always_ff @(posedge clk) begin
        if (w_load_acc)
            r_mem[r_ld_ptr] <= ld_data;
        else if (w_mem_cpu_wr)
            r_mem[addr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= LOAD;
            r_ld_ptr  <= 8'h00;
            r_io_out  <= 8'h00;
            r_io_stb  <= 1'b0;
            r_bus_err <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_io_stb <= w_io_wr;
            if (w_io_wr)
                r_io_out <= data_in;
            if (w_conflict || w_prot_err)
                r_bus_err <= 1'b1;
            case (r_state)
                LOAD: begin
                    if (ld_valid) begin
                        r_ld_ptr <= r_ld_ptr + 8'd1;
                        if (ld_last || (r_ld_ptr == 8'hFF)) begin
                            r_state   <= RUN;
                            r_cpu_rst <= 1'b0;
                        end
                    end
                end
                RUN: ;
                default: r_state <= LOAD;
            endcase
        end
    end

    assign mem_in   = w_rd_data;
    assign ld_ready = rst && (r_state == LOAD);
    assign cpu_rst  = r_cpu_rst;
    assign io_out   = r_io_out;
    assign io_stb   = r_io_stb;
    assign bus_err  = r_bus_err;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter IO_ADDR, default 8'hFF: address of the memory-mapped output port.
REQ-002 SHALL have parameter STAT_ADDR, default 8'hFE: address of the read-only status byte.
REQ-003 SHALL have parameter PROT_TOP, default 8'h3F: highest write-protected address; used only under DMEM_WPROT_EN.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port R  input  1: CPU read strobe, active-low.
REQ-007 SHALL have port W  input  1: CPU write strobe, active-low.
REQ-008 SHALL have port addr  input  8: CPU address.
REQ-009 SHALL have port data_in  input  8: CPU write data.
REQ-010 SHALL have port mem_in  output  8: read data returned to the CPU.
REQ-011 SHALL have port ld_valid  input  1: loader byte valid.
REQ-012 SHALL have port ld_data  input  8: loader byte.
REQ-013 SHALL have port ld_last  input  1: marks final loader byte.
REQ-014 SHALL have port ld_ready  output  1: responder accepts a loader byte this cycle.
REQ-015 SHALL have port cpu_rst  output  1: active-high reset to the CPU.
REQ-016 SHALL have port io_out  output  8: latched output port value.
REQ-017 SHALL have port io_stb  output  1: one-cycle pulse after an io_out write.
REQ-018 SHALL have port bus_err  output  1: sticky bus-error flag.

Function
REQ-019 SHALL contain a 256x8 storage array plus an FSM with states LOAD and RUN.
REQ-020 SHALL, in LOAD, drive ld_ready=1, cpu_rst=1, mem_in=0, and ignore R/W.
REQ-021 SHALL, in LOAD, write ld_data to mem[ld_ptr] and increment the 8-bit ld_ptr on each clock with ld_valid=1 and ld_ready=1.
REQ-022 SHALL move LOAD->RUN on the clock edge that accepts a byte with ld_last=1, or that accepts the byte at ld_ptr=8'hFF (array full; ld_ptr wraps to 0).
REQ-023 SHALL, in RUN, drive ld_ready=0 and cpu_rst=0; loader inputs ignored.
REQ-024 SHALL, in RUN with R=0, drive mem_in combinationally in the same cycle: io_out at IO_ADDR, {7'b0,bus_err} at STAT_ADDR, else mem[addr]; mem_in=0 whenever R=1.
REQ-025 SHALL, in RUN with W=0 and R=1, on the rising edge write data_in to mem[addr]; at IO_ADDR load io_out instead; at STAT_ADDR discard the write.
REQ-026 SHALL assert io_stb for exactly the one cycle following each accepted IO_ADDR write; back-to-back writes hold io_stb high continuously.
REQ-027 SHALL, when R=0 and W=0 together in RUN, service the read, suppress the write, and set bus_err.
REQ-028 SHALL keep bus_err set until reset.

Reset
REQ-029 SHALL, on any clock with rst=0, force state=LOAD, ld_ptr=0, io_out=0, io_stb=0, bus_err=0, cpu_rst=1, including mid-load or mid-run.
REQ-030 SHALL hold ld_ready=0 and mem_in=0 while rst=0.
REQ-031 SHALL NOT clear the storage array on reset.

Configuration
REQ-032 SHALL, with DMEM_WPROT_EN defined, suppress RUN-state writes with addr<=PROT_TOP and set bus_err; loader writes unaffected.
REQ-033 SHALL, without DMEM_WPROT_EN, accept RUN-state writes to every storage address; PROT_TOP has no effect.

Verification
REQ-034 SHALL cover: reset, load 8'h12,8'h34,8'h56 (last on third) -> ld_ready falls and cpu_rst falls next cycle; R=0 addr 1 -> mem_in=8'h34 same cycle.
REQ-035 SHALL cover: load 256 bytes with ld_last=0 -> RUN entered after 256th byte, ld_ptr=0, mem[8'hFF] holds byte 256.
REQ-036 SHALL cover: RUN, W=0 addr 8'hFF data 8'hA5 -> io_out=8'hA5, io_stb high one cycle; R=0 addr 8'hFF -> mem_in=8'hA5.
REQ-037 SHALL cover: RUN, R=0 and W=0 addr 8'h80 data 8'h77 -> mem[8'h80] unchanged, bus_err=1; R=0 addr 8'hFE -> mem_in=8'h01.
REQ-038 SHALL cover: DMEM_WPROT_EN defined, W=0 addr 8'h10 data 8'hEE -> mem[8'h10] unchanged, bus_err=1; undefined -> mem[8'h10]=8'hEE, bus_err=0.
REQ-039 SHALL cover: rst=0 for one cycle mid-RUN -> state LOAD, cpu_rst=1, io_out=0, previously loaded bytes still readable after reload with ld_last on the first byte.
